// File: rtl/nrisc_data_mem.sv
// rtl/nrisc_data_mem.sv - NRISC data-port responder: word RAM plus a small memory-mapped I/O window.
// Loads return with one cycle of latency and the core never sees a wait state.
module nrisc_data_mem #(
    parameter int unsigned TAM     = 16,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned IO_BASE = 32'hFFF0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [TAM-1:0] DATA_IN,
    output logic [TAM-1:0] DATA_Out,
    input  logic           CORE_DATA_write,
    input  logic           CORE_DATA_load,
    input  logic [TAM-1:0] CORE_DATA_ADDR,
    input  logic [TAM-1:0] GPIO_IN,
    output logic [TAM-1:0] GPIO_OUT,
    output logic           MEM_fault
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  IO_LO = 4'(IO_BASE);

    localparam logic [3:0] OFF_GPIO_OUT = 4'd0;
    localparam logic [3:0] OFF_GPIO_IN  = 4'd1;
    localparam logic [3:0] OFF_CYCLE    = 4'd2;
    localparam logic [3:0] OFF_FAULT    = 4'd3;

    if (DEPTH > IO_BASE) begin : g_bad_depth
        $error("nrisc_data_mem: DEPTH overlaps the I/O window");
    end

    logic [TAM-1:0] mem [DEPTH];

    logic [TAM-1:0] cycle_cnt;
    logic [TAM-1:0] fault_addr;
    logic [TAM-1:0] gpio_s1;
    logic [TAM-1:0] gpio_s2;

    logic [31:0]    addr_ext;
    logic [AW-1:0]  ram_idx;
    logic [3:0]     io_off;
    logic           in_ram;
    logic           in_io;
    logic           io_reg;
    logic           sel_gpio_out;
    logic           sel_gpio_in;
    logic           sel_cycle;
    logic           sel_fault;
    logic           mapped;
    logic           read_only;
    logic           fault_hit;
    logic           fault_clr;
    logic [TAM-1:0] rd_val;
    logic [TAM-1:0] load_val;

    always_comb begin
        addr_ext     = 32'(CORE_DATA_ADDR);
        ram_idx      = CORE_DATA_ADDR[AW-1:0];
        io_off       = CORE_DATA_ADDR[3:0] - IO_LO;
        in_ram       = addr_ext < DEPTH;
        in_io        = (addr_ext >= IO_BASE) && (addr_ext <= IO_BASE + 32'd15);
        // Only the first four window slots are real registers; the rest behave as unmapped.
        io_reg       = in_io && (io_off < 4'd4);
        sel_gpio_out = io_reg && (io_off == OFF_GPIO_OUT);
        sel_gpio_in  = io_reg && (io_off == OFF_GPIO_IN);
        sel_cycle    = io_reg && (io_off == OFF_CYCLE);
        sel_fault    = io_reg && (io_off == OFF_FAULT);
        mapped       = in_ram || io_reg;
        read_only    = sel_gpio_in || sel_fault;
        fault_hit    = (CORE_DATA_write || CORE_DATA_load) && !mapped;
        fault_clr    = CORE_DATA_write && sel_fault;

        rd_val = '0;
        if (in_ram) begin
            rd_val = mem[ram_idx];
        end else if (sel_gpio_out) begin
            rd_val = GPIO_OUT;
        end else if (sel_gpio_in) begin
            rd_val = gpio_s2;
        end else if (sel_cycle) begin
            rd_val = cycle_cnt;
        end else if (sel_fault) begin
            rd_val = fault_addr;
        end

        // Write-through forwarding, except read-only registers report their pre-write value.
        load_val = rd_val;
        if (CORE_DATA_write && mapped && !read_only) begin
            load_val = DATA_IN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && CORE_DATA_write && in_ram) begin
            mem[ram_idx] <= DATA_IN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            DATA_Out   <= '0;
            GPIO_OUT   <= '0;
            cycle_cnt  <= '0;
            MEM_fault  <= 1'b0;
            fault_addr <= '0;
            gpio_s1    <= '0;
            gpio_s2    <= '0;
        end else begin
            gpio_s1 <= GPIO_IN;
            gpio_s2 <= gpio_s1;

            if (CORE_DATA_load) begin
                DATA_Out <= load_val;
            end

            if (CORE_DATA_write && sel_gpio_out) begin
                GPIO_OUT <= DATA_IN;
            end

            // A write zeroes the count at this edge; the free-running +1 still applies.
            if (CORE_DATA_write && sel_cycle) begin
                cycle_cnt <= TAM'(1);
            end else begin
                cycle_cnt <= cycle_cnt + TAM'(1);
            end

            if (fault_clr) begin
                MEM_fault  <= 1'b0;
                fault_addr <= '0;
            end else if (fault_hit) begin
                MEM_fault <= 1'b1;
                if (!MEM_fault) begin
                    fault_addr <= CORE_DATA_ADDR;
                end
            end
        end
    end

endmodule

// File: tb/tb_nrisc_data_mem.sv
// tb/tb_nrisc_data_mem.sv - self-checking bench for nrisc_data_mem against a behavioural model.
module tb_nrisc_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic        ld;
    logic [15:0] din;
    logic [15:0] addr;
    logic [15:0] gpio_in;
    logic [15:0] dout;
    logic [15:0] gpio_out;
    logic        fault;

    always #5 clk = ~clk;

    nrisc_data_mem #(
        .TAM    (16),
        .DEPTH  (1024),
        .IO_BASE(32'hFFF0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .DATA_IN        (din),
        .DATA_Out       (dout),
        .CORE_DATA_write(wr),
        .CORE_DATA_load (ld),
        .CORE_DATA_ADDR (addr),
        .GPIO_IN        (gpio_in),
        .GPIO_OUT       (gpio_out),
        .MEM_fault      (fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: edge numbers stand in for time, so the counter and synchroniser are pure arithmetic.
    int          edge_n   = 0;
    int          rst_edge = 0;
    int          cyc_base = 0;
    logic [15:0] gpio_val = 16'h0;
    logic [15:0] m_ram  [int];
    logic [15:0] m_hist [int];
    logic [15:0] m_gpio_out = 16'h0;
    logic [15:0] m_faddr    = 16'h0;
    logic [15:0] m_dout     = 16'h0;
    logic        m_fault    = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a < 16'd1024) return m_ram.exists(int'(a)) ? m_ram[int'(a)] : 16'h0;
        case (a)
            16'hFFF0: return m_gpio_out;
            16'hFFF1: return (edge_n - 2 > rst_edge && m_hist.exists(edge_n - 2)) ? m_hist[edge_n - 2] : 16'h0;
            16'hFFF2: return 16'(edge_n - cyc_base);
            16'hFFF3: return m_faddr;
            default:  return 16'h0;
        endcase
    endfunction

    task automatic step(input logic r, input logic w, input logic l, input logic [15:0] a, input logic [15:0] d);
        logic        is_ram;
        logic        is_reg;
        logic [15:0] v;
        rst = r; wr = w; ld = l; addr = a; din = d; gpio_in = gpio_val;
        @(posedge clk);
        edge_n++;
        if (r) begin
            m_dout     = 16'h0;
            m_gpio_out = 16'h0;
            m_fault    = 1'b0;
            m_faddr    = 16'h0;
            cyc_base   = edge_n + 1;
            rst_edge   = edge_n;
        end else begin
            is_ram = (a < 16'd1024);
            is_reg = (a >= 16'hFFF0) && (a <= 16'hFFF3);
            v = model_read(a);
            if (l) m_dout = (w && (is_ram || a == 16'hFFF0 || a == 16'hFFF2)) ? d : v;
            if (w && is_ram) m_ram[int'(a)] = d;
            if (w && a == 16'hFFF0) m_gpio_out = d;
            if (w && a == 16'hFFF2) cyc_base = edge_n;
            if (w && a == 16'hFFF3) begin
                m_fault = 1'b0;
                m_faddr = 16'h0;
            end
            if ((w || l) && !is_ram && !is_reg) begin
                if (!m_fault) m_faddr = a;
                m_fault = 1'b1;
            end
        end
        m_hist[edge_n] = gpio_val;
        #1;
        check("dout", dout, m_dout);
        check("gpio_out", gpio_out, m_gpio_out);
        check("fault", {15'h0, fault}, {15'h0, m_fault});
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: a = 16'($urandom_range(0, 31));
            4:          a = 16'd1023;
            5:          a = 16'd1024;
            6:          a = 16'hFFEF;
            7, 8:       a = 16'hFFF0 + 16'($urandom_range(0, 15));
            default:    a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        endcase
        return a;
    endfunction

    initial begin
        rst = 1'b1; wr = 1'b0; ld = 1'b0; addr = 16'h0; din = 16'h0; gpio_in = 16'h0;
        step(1, 0, 0, 16'h0, 16'h0);
        step(0, 0, 1, 16'hFFF2, 16'h0);
        check("reset_cycle", dout, 16'h0);
        check("reset_gpio_out", gpio_out, 16'h0);

        for (int i = 0; i < 32; i++) step(0, 1, 0, 16'(i), 16'($urandom));
        step(0, 1, 0, 16'd1023, 16'($urandom));

        step(0, 1, 0, 16'd5, 16'hBEEF);
        step(0, 0, 1, 16'd5, 16'h0);
        check("ram_load", dout, 16'hBEEF);
        step(0, 0, 0, 16'd6, 16'h1111);
        check("ram_hold", dout, 16'hBEEF);

        step(0, 1, 1, 16'd7, 16'h1234);
        check("fwd", dout, 16'h1234);
        step(0, 0, 1, 16'd0, 16'h0);
        step(0, 0, 1, 16'd7, 16'h0);
        check("fwd_stored", dout, 16'h1234);

        step(0, 1, 0, 16'hFFF0, 16'h00A5);
        check("gpio_out_wr", gpio_out, 16'h00A5);
        gpio_val = 16'h1111;
        repeat (3) step(0, 0, 0, 16'h0, 16'h0);
        gpio_val = 16'h3C3C;
        step(0, 0, 0, 16'h0, 16'h0);
        step(0, 0, 1, 16'hFFF1, 16'h0);
        check("gpio_sync_1st", dout, 16'h1111);
        step(0, 0, 1, 16'hFFF1, 16'h0);
        check("gpio_sync_2nd", dout, 16'h3C3C);
        step(0, 1, 1, 16'hFFF1, 16'h7777);
        check("gpio_in_ro", dout, 16'h3C3C);

        step(0, 1, 0, 16'hFFF2, 16'hABCD);
        repeat (9) step(0, 0, 0, 16'h0, 16'h0);
        step(0, 0, 1, 16'hFFF2, 16'h0);
        check("cycle_10", dout, 16'd10);
        repeat (65535) step(0, 0, 0, 16'h0, 16'h0);
        step(0, 0, 1, 16'hFFF2, 16'h0);
        check("cycle_wrap", dout, 16'd10);

        step(0, 0, 1, 16'h8000, 16'h0);
        check("unmapped_rd", dout, 16'h0);
        check("fault_set", {15'h0, fault}, 16'h1);
        step(0, 1, 0, 16'hFFF9, 16'h4444);
        step(0, 0, 1, 16'hFFF3, 16'h0);
        check("fault_first", dout, 16'h8000);
        step(0, 1, 0, 16'hFFF3, 16'h0);
        check("fault_clr", {15'h0, fault}, 16'h0);
        step(0, 0, 1, 16'hFFF3, 16'h0);
        check("faddr_clr", dout, 16'h0);
        step(0, 0, 1, 16'd1024, 16'h0);
        check("boundary_1024", {15'h0, fault}, 16'h1);

        step(0, 1, 0, 16'hFFF0, 16'h9999);
        step(0, 0, 1, 16'd5, 16'h0);
        step(1, 1, 0, 16'hFFF0, 16'h5555);
        check("rst_gpio", gpio_out, 16'h0);
        check("rst_dout", dout, 16'h0);
        check("rst_fault", {15'h0, fault}, 16'h0);
        step(0, 0, 1, 16'hFFF2, 16'h0);
        check("rst_cycle", dout, 16'h0);

        for (int i = 0; i < 2000; i++) begin
            gpio_val = 16'($urandom);
            step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), rand_addr(), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
